// File: rtl/pps_counter_pkg.sv
// Shared types and defaults for the PPS window counter.
// Latency: n/a (types only). Backpressure: n/a.
// Carries the FSM state encoding and the default watchdog limit.
package pps_counter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Slightly more than one PPS period at a 100 MHz system clock.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 110_000_000;

endpackage

// File: rtl/pps_edge_sync.sv
// Synchronises the asynchronous PPS pin and emits a one-cycle strobe on its rising edge.
// Latency: pps_in rise to pps_edge is SYNC_STAGES+1 cycles. Backpressure: none, free-running.
// A pulse shorter than one system_clk period may be missed.
module pps_edge_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic system_clk,
    input  logic rst,
    input  logic pps_in,
    output logic pps_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // The strobe is registered so downstream logic sees a clean one-cycle pulse.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            pps_edge <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pps_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            pps_edge <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/pps_window_counter.sv
// Counts system_clk cycles over window_len+1 PPS periods and latches the total with a valid/ack handshake.
// Latency: edge strobe to result/result_valid 1 cycle; result_ack to result_valid low 1 cycle. Backpressure: none, an unacked result is overwritten and flagged in overrun.
// Optional missing-pulse watchdog enabled by defining PPS_WINDOW_COUNTER_WATCHDOG_EN.
module pps_window_counter
    import pps_counter_pkg::*;
#(
    parameter int          COUNTERWIDTH   = 32,
    parameter int          WINDOWWIDTH    = 5,
    parameter int          SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    system_clk,
    input  logic                    rst,
    input  logic                    pps_in,
    input  logic [WINDOWWIDTH-1:0]  window_len,
    output logic [COUNTERWIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ack,
    output logic                    saturated,
    output logic                    overrun,
    output logic                    pps_lost,
    output logic                    armed
);

    localparam logic [COUNTERWIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTERWIDTH-1:0] CNT_ONE = COUNTERWIDTH'(1);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("pps_window_counter: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t                  state_q, state_d;
    logic [COUNTERWIDTH-1:0] count_q;
    logic [WINDOWWIDTH-1:0]  edges_q;
    logic [WINDOWWIDTH-1:0]  target_q;
    logic                    sat_q;
    logic                    pps_edge;
    logic                    latch;
    logic                    timeout;

    pps_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .system_clk (system_clk),
        .rst        (rst),
        .pps_in     (pps_in),
        .pps_edge   (pps_edge)
    );

`ifdef PPS_WINDOW_COUNTER_WATCHDOG_EN
    localparam int SILENCE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SILENCE_W-1:0] silence_q;
    logic                 lost_q;

    // silence_q equals cycles since the last edge, so the timeout lands exactly TIMEOUT_CYCLES after it.
    assign timeout  = (state_q == COUNT) && !pps_edge
                      && (silence_q == SILENCE_W'(TIMEOUT_CYCLES - 1));
    assign pps_lost = lost_q;
`else
    assign timeout  = 1'b0;
    assign pps_lost = 1'b0;
`endif

    assign armed = (state_q == COUNT);

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pps_edge) state_d = COUNT;
            end
            COUNT: begin
                if (pps_edge && (edges_q == target_q)) latch = 1'b1;
                if (timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            edges_q      <= '0;
            target_q     <= '0;
            sat_q        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            saturated    <= 1'b0;
            overrun      <= 1'b0;
`ifdef PPS_WINDOW_COUNTER_WATCHDOG_EN
            silence_q    <= '0;
            lost_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (state_q == IDLE) begin
                if (pps_edge) begin
                    count_q  <= CNT_ONE;
                    edges_q  <= '0;
                    target_q <= window_len;
                    sat_q    <= 1'b0;
                end
            end else if (latch) begin
                result       <= count_q;
                saturated    <= sat_q;
                result_valid <= 1'b1;
                overrun      <= result_valid && !result_ack;
                count_q      <= CNT_ONE;
                edges_q      <= '0;
                sat_q        <= 1'b0;
                target_q     <= window_len;
            end else if (!timeout) begin
                // Hold at all-ones and remember that the window total was clipped.
                if (count_q == CNT_MAX) sat_q <= 1'b1;
                else                    count_q <= count_q + 1'b1;
                if (pps_edge) edges_q <= edges_q + 1'b1;
            end

            if (result_ack && !latch) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end

`ifdef PPS_WINDOW_COUNTER_WATCHDOG_EN
            if (pps_edge) begin
                silence_q <= SILENCE_W'(1);
                lost_q    <= 1'b0;
            end else if (state_q == COUNT) begin
                silence_q <= silence_q + 1'b1;
            end
            if (timeout) lost_q <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/pps_window_counter.md
# pps_window_counter

Parametrised GPS-disciplined frequency counter. It counts `system_clk` cycles across a programmable window of whole GPS PPS periods and latches the total for the host, using a valid/ack handshake with overrun and saturation flags. It sits between the GPS pulse pin and the SPI register map, and is the generalised successor of the inline PPS counter in the top level. An optional missing-pulse watchdog is included.

## Interface
- `COUNTERWIDTH`, 32: width of cycle counter and result.
- `WINDOWWIDTH`, 5: width of window length; window = `window_len`+1 PPS periods.
- `SYNC_STAGES`, 3: flip-flop stages on `pps_in`, minimum 2.
- `TIMEOUT_CYCLES`, 110000000: watchdog limit in cycles; only used with the watchdog enabled.

Ports:
- `system_clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `pps_in` in 1: asynchronous GPS pulse.
- `window_len` in WINDOWWIDTH: window length minus one; sampled at each window start.
- `result` out COUNTERWIDTH: cycles in the last completed window.
- `result_valid` out 1: `result` holds unread data.
- `result_ack` in 1: one-cycle consume strobe.
- `saturated` out 1: `result` was clipped at all-ones.
- `overrun` out 1: an unacked result was overwritten.
- `pps_lost` out 1: watchdog fired; sticky until the next edge.
- `armed` out 1: a window is in progress.

## Operation
- `pps_in` passes through `SYNC_STAGES` flip-flops.
- A rising edge is detected as previous=0, current=1. This produces `edge`, a one-cycle strobe.
- State IDLE (entered on reset):
  - Wait for `edge`.
  - On `edge`: counter<=1, edges<=0, target<=`window_len`, go to COUNT.
  - No result is produced in IDLE.
- State COUNT, each cycle without `edge`:
  - Counter increments and saturates at all-ones.
  - A sticky `sat_int` is set when the counter saturates.
- State COUNT, on `edge` with edges≠target:
  - edges++.
  - Counter increments as normal.
- State COUNT, on `edge` with edges==target:
  - `result`<=counter, `saturated`<=`sat_int`, `result_valid`<=1.
  - Counter<=1, edges<=0, `sat_int`<=0, target<=`window_len`.
  - Remain in COUNT.
- The latched value equals the exact cycle count between the first and last edge strobes of the window.
- Handshake:
  - `result_ack` with no latch in the same cycle: `result_valid`<=0, `overrun`<=0.
  - Latch while `result_valid`=1 and no ack: overwrite `result`, set `overrun`.
  - Latch and `result_ack` in the same cycle: new result wins, `result_valid` stays 1, `overrun`<=0.
  - `result_ack` while `result_valid`=0: no effect.
- `armed` = (state==COUNT).
- A `window_len` change mid-window takes effect at the next window start only.

## Timing
- Reset values: `result`=0, `result_valid`=0, `saturated`=0, `overrun`=0, `pps_lost`=0, `armed`=0, state IDLE.
- Reset mid-window discards the partial count. The first post-reset window starts at the next edge.
- `pps_in` rising to `edge`: `SYNC_STAGES`+1 cycles.
- `edge` to `result_valid`=1 and new `result`: 1 cycle (registered).
- `result_ack` to `result_valid`=0: 1 cycle.
- Arithmetic is unsigned. The counter never wraps.
- `edges` is WINDOWWIDTH bits wide and cannot exceed target.

## Configuration
- `PPS_WINDOW_COUNTER_WATCHDOG_EN` defined:
  - In COUNT, a silence counter resets on each `edge`.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, discard the partial window, set `pps_lost`.
  - `pps_lost` clears on the next `edge`, which also starts a new window.
  - `result`, `result_valid` and `overrun` are untouched by a timeout.
- `PPS_WINDOW_COUNTER_WATCHDOG_EN` undefined:
  - No silence counter is built and `pps_lost` is tied to 0.
  - A lost PPS leaves the block in COUNT with the counter saturated.

## Structure
- Package `pps_counter_pkg`: state encoding constants (IDLE, COUNT) and default `TIMEOUT_CYCLES`.
- Sub-module `pps_edge_sync`: holds the synchronizer and rising-edge detector, parametrised by `SYNC_STAGES`, with output `edge`.
- All remaining logic stays in one always block, clocked by `system_clk` with synchronous reset on `rst`.

## Test plan
- `window_len`=0, PPS every 1000 cycles, ack each result -> first edge produces no result; each later edge gives `result`=1000, `saturated`=0.
- `window_len`=3, period 1000 -> `result`=4000 on every 4th edge after arming. Change to 1 mid-window -> current window still yields 4000, the next yields 2000.
- Two results without ack -> `overrun`=1, `result` holds the second value. Ack -> `result_valid`=0, `overrun`=0. Ack in the latch cycle -> `result_valid` stays 1, `overrun`=0.
- `COUNTERWIDTH`=8, period 300 -> `result`=255, `saturated`=1. The next window at period 200 -> `result`=200, `saturated`=0.
- Watchdog on, `TIMEOUT_CYCLES`=5000, pulses stop -> `pps_lost`=1 and `armed`=0 exactly 5000 cycles after the last edge. Pulses resume -> first edge clears `pps_lost` without a result; the next edge gives a correct result.
- Assert `rst` mid-window -> all outputs 0 next cycle; first edge after reset only arms.
